w_frame_tx: RTL

//   Serial stimulus transmitter that drives the 1-bit w input of the sequence-detector FSM.

---
 rtl/w_frame_tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/w_frame_tx.sv
// Serial frame transmitter for the sequence detector's w input: ones_len ones, then zeros, FRAME_LEN bits per frame.
// Optional W_FRAME_TX_EXPECT_EN adds z_exp, a reference model of the four-in-a-row detector output.
module w_frame_tx #(
  parameter int FRAME_LEN = 10,
  parameter int CNT_W     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] ones_len,
  output logic             ready,
  output logic             w,
  output logic             w_valid,
  output logic             frame_done
`ifdef W_FRAME_TX_EXPECT_EN
  ,
  output logic             z_exp
`endif
);

  typedef enum logic [1:0] {IDLE, ONES, ZEROS} state_e;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             ready_q, ready_d;
  logic             w_q, w_d;
  logic             w_valid_q, w_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] len_clamped;

  always_comb begin
    len_clamped = (ones_len > FULL) ? FULL : ones_len;
  end

  // Outputs are computed for the cycle after the edge, so the state names the bit being driven.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    bit_cnt_d    = bit_cnt_q;
    ready_d      = 1'b0;
    w_d          = 1'b0;
    w_valid_d    = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          len_d     = len_clamped;
          bit_cnt_d = '0;
          ready_d   = 1'b0;
          w_valid_d = 1'b1;
          if (len_clamped != '0) begin
            state_d = ONES;
            w_d     = 1'b1;
          end else begin
            state_d = ZEROS;
          end
        end
      end
      ONES: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == len_q - 1'b1) begin
          if (len_q == FULL) begin
            state_d      = IDLE;
            bit_cnt_d    = '0;
            ready_d      = 1'b1;
            frame_done_d = 1'b1;
          end else begin
            state_d   = ZEROS;
            w_valid_d = 1'b1;
          end
        end else begin
          w_d       = 1'b1;
          w_valid_d = 1'b1;
        end
      end
      ZEROS: begin
        if (bit_cnt_q == LAST) begin
          state_d      = IDLE;
          bit_cnt_d    = '0;
          ready_d      = 1'b1;
          frame_done_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          w_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      bit_cnt_q    <= '0;
      ready_q      <= 1'b1;
      w_q          <= 1'b0;
      w_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      bit_cnt_q    <= bit_cnt_d;
      ready_q      <= ready_d;
      w_q          <= w_d;
      w_valid_q    <= w_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ready      = ready_q;
  assign w          = w_q;
  assign w_valid    = w_valid_q;
  assign frame_done = frame_done_q;

`ifdef W_FRAME_TX_EXPECT_EN
  logic [2:0] run_cnt_q, run_cnt_d;
  logic       prev_w_q;
  logic       z_exp_q, z_exp_d;

  // Samples the bit currently on w, exactly as the detector does at this edge.
  always_comb begin
    run_cnt_d = '0;
    if (w_valid_q) begin
      if (run_cnt_q != '0 && w_q == prev_w_q) begin
        run_cnt_d = (run_cnt_q == 3'd4) ? 3'd4 : run_cnt_q + 3'd1;
      end else begin
        run_cnt_d = 3'd1;
      end
    end
    z_exp_d = (run_cnt_d == 3'd4);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_cnt_q <= '0;
      prev_w_q  <= 1'b0;
      z_exp_q   <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      prev_w_q  <= w_q;
      z_exp_q   <= z_exp_d;
    end
  end

  assign z_exp = z_exp_q;
`endif

endmodule
